// File: rtl/score_display.sv
// Four-digit common-anode seven-segment driver: binary score -> BCD (shift-and-add-3), saturate at 9999,
// leading-zero blanking, digit multiplexing. Conversion takes 17 cycles; the display updates the cycle after.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e       state_q, state_d;
    logic [15:0]  last_score_q, last_score_d;
    logic [15:0]  shift_in_q, shift_in_d;
    logic [15:0]  bcd_q, bcd_d, bcd_adj;
    logic [3:0]   iter_q, iter_d;
    logic [15:0]  digits_q, digits_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   an_q, an_d;
    logic [6:0]   seg_q, seg_d;
    logic [3:0]   blank;
    logic [3:0]   sel_nib;
    logic         score_changed;

    function automatic logic [6:0] seg_pat(input logic [3:0] n);
        case (n)
            4'd0:    seg_pat = 7'b1000000;
            4'd1:    seg_pat = 7'b1111001;
            4'd2:    seg_pat = 7'b0100100;
            4'd3:    seg_pat = 7'b0110000;
            4'd4:    seg_pat = 7'b0011001;
            4'd5:    seg_pat = 7'b0010010;
            4'd6:    seg_pat = 7'b0000010;
            4'd7:    seg_pat = 7'b1111000;
            4'd8:    seg_pat = 7'b0000000;
            4'd9:    seg_pat = 7'b0010000;
            default: seg_pat = 7'b1111111;
        endcase
    endfunction

    assign score_changed = (score != last_score_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (score_changed) state_d = SHIFT;
            SHIFT:   if (iter_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        last_score_d = last_score_q;
        shift_in_d   = shift_in_q;
        bcd_d        = bcd_q;
        iter_d       = iter_q;
        digits_d     = digits_q;
        case (state_q)
            IDLE: begin
                if (score_changed) begin
                    last_score_d = score;
                    shift_in_d   = (score > 16'd9999) ? 16'd9999 : score;
                    bcd_d        = '0;
                    iter_d       = '0;
                end
            end
            SHIFT: begin
                {bcd_d, shift_in_d} = {bcd_adj, shift_in_q} << 1;
                iter_d = iter_q + 4'd1;
            end
            DONE:    digits_d = bcd_q;
            default: ;
        endcase
    end

    // A digit blanks only when it and every digit to its left is zero; ones never blanks.
    always_comb begin
        blank[3] = (digits_q[15:12] == 4'd0);
        blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
        blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
        blank[0] = 1'b0;
        sel_nib  = digits_q[4*idx_q +: 4];
    end

    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        idx_d      = (scan_cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
        an_d       = ~(4'b0001 << idx_q);
        seg_d      = blank[idx_q] ? 7'b1111111 : seg_pat(sel_nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_score_q <= '0;
            shift_in_q   <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            digits_q     <= '0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
        end else begin
            last_score_q <= last_score_d;
            shift_in_q   <= shift_in_d;
            bcd_q        <= bcd_d;
            iter_q       <= iter_d;
            digits_q     <= digits_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display with a decimal-arithmetic reference model and per-cycle compare.
module tb_score_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] score = 16'd0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    score_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .score(score),
        .seg(seg), .an(an), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a conversion is a 17-cycle window after which the saturated value is shown;
    // the lit digit follows the elapsed cycle count since reset.
    int m_last = 0, m_tgt = 0, m_rem = 0, m_disp = 0, m_n = 0;
    logic [3:0] exp_an = 4'hf;
    logic [6:0] exp_seg = 7'h7f;

    function automatic logic [6:0] digit_seg(input int v, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i > 0 && v < p) return 7'h7f;
        return pat[(v / p) % 10];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 0; m_tgt = 0; m_rem = 0; m_disp = 0; m_n = 0;
            exp_an = 4'hf; exp_seg = 7'h7f;
        end else begin
            int ix;
            ix = (m_n / RD) % 4;
            exp_an  = ~(4'b0001 << ix);
            exp_seg = digit_seg(m_disp, ix);
            m_n++;
            if (m_rem == 0) begin
                if (int'(score) != m_last) begin
                    m_last = int'(score);
                    m_tgt  = (score > 16'd9999) ? 9999 : int'(score);
                    m_rem  = 17;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_disp = m_tgt;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (m_rem > 0);
        checks++;
        if (an !== exp_an || seg !== exp_seg || busy !== exp_busy || dp !== 1'b1) begin
            errors++;
            if (errors < 30)
                $display("FAIL cycle t=%0t an=%b/%b seg=%b/%b busy=%b/%b dp=%b (got/want)",
                         $time, an, exp_an, seg, exp_seg, busy, exp_busy, dp);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic set_score(input logic [15:0] v);
        @(posedge clk);
        #1 score = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Observe one full frame and compare each digit's pattern with a literal.
    task automatic show(input string name, input logic [6:0] w3, input logic [6:0] w2,
                        input logic [6:0] w1, input logic [6:0] w0);
        logic [6:0] got [4];
        logic [3:0] sel;
        for (int k = 0; k < 4; k++) got[k] = 7'bx;
        repeat (4 * RD) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                sel = ~(4'b0001 << k);
                if (an === sel) got[k] = seg;
            end
        end
        chk({name, "_d3"}, {25'd0, got[3]}, {25'd0, w3});
        chk({name, "_d2"}, {25'd0, got[2]}, {25'd0, w2});
        chk({name, "_d1"}, {25'd0, got[1]}, {25'd0, w1});
        chk({name, "_d0"}, {25'd0, got[0]}, {25'd0, w0});
    endtask

    initial begin
        int c;
        logic [15:0] v;

        rst_n = 1'b0;
        score = 16'd0;
        repeat (3) @(posedge clk);
        #1 chk("reset_an", {28'd0, an}, 32'hf);
        chk("reset_seg", {25'd0, seg}, 32'h7f);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("first_an", {28'd0, an}, 32'b1110);
        chk("first_seg", {25'd0, seg}, 32'b1000000);
        show("zero", 7'h7f, 7'h7f, 7'h7f, 7'b1000000);

        set_score(16'd1234);
        c = 0;
        repeat (40) @(negedge clk) if (busy) c++;
        chk("busy_len", c, 17);
        show("v1234", pat[1], pat[2], pat[3], pat[4]);

        set_score(16'd65535);
        idle(20);
        show("v65535", pat[9], pat[9], pat[9], pat[9]);
        set_score(16'd0);
        idle(20);
        set_score(16'd10000);
        idle(20);
        show("v10000", pat[9], pat[9], pat[9], pat[9]);

        set_score(16'd7);
        idle(3);
        #1 score = 16'd50;
        idle(40);
        show("v50", 7'h7f, 7'h7f, pat[5], pat[0]);

        set_score(16'd4321);
        idle(5);
        #1 rst_n = 1'b0;
        #1 chk("midrst_an", {28'd0, an}, 32'hf);
        chk("midrst_seg", {25'd0, seg}, 32'h7f);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_seg", {25'd0, seg}, 32'b1000000);
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        idle(18);
        show("v4321", pat[4], pat[3], pat[2], pat[1]);

        set_score(16'd1005);
        idle(20);
        show("v1005", pat[1], pat[0], pat[0], pat[5]);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 99));
                1:       v = 16'($urandom_range(0, 9999));
                2:       v = 16'($urandom_range(9990, 10010));
                default: v = 16'($urandom_range(0, 65535));
            endcase
            set_score(v);
            idle($urandom_range(1, 40));
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
